// File: rtl/parport_arbiter.sv
// ---------------------------------------------------------------------------
// parport_arbiter
//
// Shares one parity-protected parallel printer port among N_REQ byte
// requesters. A round-robin arbiter picks one pending requester, captures
// its byte together with an odd-parity bit, and then runs the four-phase
// strobe/ack handshake with the printer.
//
// Handshake contract, requester side (valid/ready):
//   req[i] is the "valid" of requester i and must stay high, with
//   req_data[8*i +: 8] stable, until grant[i] pulses for one cycle. The
//   pulse means the byte was captured on the previous edge; the requester
//   may then drop req[i] or present the next byte. req changes while the
//   port is busy are ignored. A requester that keeps req high competes
//   again at the next IDLE cycle.
//
// Handshake contract, printer side (four-phase):
//   parallelPort_dout is stable for SETUP_CYC cycles before strobe rises,
//   strobe stays high until ack is sampled high, then strobe drops and the
//   block waits for ack to be sampled low before the next byte.
//
// Optional feature, compile macro PARPORT_ACK_TIMEOUT_EN:
//   defined   - each of the STROBE and RELEASE waits is limited to
//               TIMEOUT_CYC cycles; on expiry the byte is abandoned, the
//               block returns to IDLE and timeout_err sets (sticky).
//   undefined - no timeout counter; timeout_err is tied low.
//
// Parameters:
//   N_REQ        number of requesters (2..8)
//   SETUP_CYC    cycles dout is stable before strobe rises (>=1)
//   TIMEOUT_CYC  ack wait limit per handshake phase (>=1)
//
// Ports:
//   clk                in   clock, all logic on posedge
//   reset              in   synchronous, active-high
//   req                in   [N_REQ-1:0] per-requester byte pending
//   req_data           in   [8*N_REQ-1:0] byte of requester i at [8*i +: 8]
//   grant              out  [N_REQ-1:0] one-hot 1-cycle capture pulse
//   ack                in   printer acknowledge (sampled on clk)
//   parallelPort_dout  out  [8:0] {odd parity, byte}
//   strobe             out  data-valid strobe to printer
//   busy               out  high whenever the FSM is not IDLE
//   owner              out  [2:0] index of the requester owning the port
//   timeout_err        out  sticky ack-timeout flag
// ---------------------------------------------------------------------------
module parport_arbiter #(
    parameter int N_REQ       = 4,
    parameter int SETUP_CYC   = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     grant,
    input  logic                 ack,
    output logic [8:0]           parallelPort_dout,
    output logic                 strobe,
    output logic                 busy,
    output logic [2:0]           owner,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int              SC_W       = $clog2(SETUP_CYC + 1);
    localparam logic [SC_W-1:0] SETUP_LAST = SC_W'(SETUP_CYC - 1);
    localparam logic [SC_W-1:0] SC_MAX     = '1;
    localparam logic [2:0]      PTR_RST    = 3'(N_REQ - 1);

    state_t            state;
    state_t            state_nx;
    logic [2:0]        ptr;
    logic [SC_W-1:0]   setup_cnt;

    logic              win_found;
    logic [2:0]        win_idx;
    logic [7:0]        win_byte;
    logic [N_REQ-1:0]  win_onehot;
    logic              to_hit;

    // Round-robin pick. Requesters above the last winner outrank those at or
    // below it; within each group the lowest index wins. Scanning downward
    // and letting the last hit stand yields the lowest index, and the upper
    // group is scanned second so it overrides the lower one.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = 3'd0;
        win_byte   = 8'h00;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k] && (k <= int'(ptr))) begin
                win_found = 1'b1;
                win_idx   = 3'(k);
                win_byte  = req_data[8*k +: 8];
            end
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k] && (k > int'(ptr))) begin
                win_found = 1'b1;
                win_idx   = 3'(k);
                win_byte  = req_data[8*k +: 8];
            end
        end
        win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
    end

    // Next-state logic. A sampled ack always takes precedence over an
    // expiring timeout in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (win_found)                state_nx = ST_SETUP;
            ST_SETUP:   if (setup_cnt >= SETUP_LAST)  state_nx = ST_STROBE;
            ST_STROBE:  if (ack)                      state_nx = ST_RELEASE;
                        else if (to_hit)              state_nx = ST_IDLE;
            ST_RELEASE: if (!ack || to_hit)           state_nx = ST_IDLE;
            default:                                  state_nx = ST_IDLE;
        endcase
    end

    assign strobe = (state == ST_STROBE);
    assign busy   = (state != ST_IDLE);

    // State register and capture path. dout only ever changes on the
    // arbitration edge, so it is stable for the whole handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            grant             <= '0;
            parallelPort_dout <= 9'h100;
            owner             <= 3'd0;
            ptr               <= PTR_RST;
            setup_cnt         <= '0;
        end else begin
            state <= state_nx;
            grant <= '0;
            if (state == ST_IDLE && win_found) begin
                grant             <= win_onehot;
                parallelPort_dout <= {~^win_byte, win_byte};
                owner             <= win_idx;
                ptr               <= win_idx;
                setup_cnt         <= '0;
            end else if (state == ST_SETUP && setup_cnt != SC_MAX) begin
                setup_cnt <= setup_cnt + SC_W'(1);
            end
        end
    end

`ifdef PARPORT_ACK_TIMEOUT_EN
    localparam int              TO_W    = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_MAX  = '1;

    logic [TO_W-1:0] to_cnt;
    logic            to_fire;

    // to_cnt holds the number of cycles already spent in the current wait
    // state, so the wait ends after exactly TIMEOUT_CYC cycles.
    assign to_hit  = (to_cnt >= TO_LAST);
    assign to_fire = to_hit && (((state == ST_STROBE) && !ack) ||
                                ((state == ST_RELEASE) && ack));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_nx != state) begin
                to_cnt <= '0;
            end else if ((state == ST_STROBE || state == ST_RELEASE) && to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (to_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_parport_arbiter.sv
// ---------------------------------------------------------------------------
// tb_parport_arbiter
//
// Directed bench for parport_arbiter. The printer is modelled by echoing
// strobe back as ack two clocks later; ack can be forced low to provoke the
// ack-wait timeout. Every strobe rise is checked for odd parity and against
// an expected-dout queue; every grant is checked against an expected-grant
// queue, so unexpected bytes or grants are reported.
// ---------------------------------------------------------------------------
module tb_parport_arbiter;

  localparam int N_REQ       = 4;
  localparam int SETUP_CYC   = 2;
  localparam int TIMEOUT_CYC = 8;
  localparam int PERIOD      = 1 + SETUP_CYC + 3 + 3;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N_REQ-1:0]   req = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]   grant;
  logic               ack = 1'b0;
  logic [8:0]         dout;
  logic               strobe;
  logic               busy;
  logic [2:0]         owner;
  logic               timeout_err;

  always #5 clk = ~clk;

  parport_arbiter #(
    .N_REQ       (N_REQ),
    .SETUP_CYC   (SETUP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .req_data          (req_data),
    .grant             (grant),
    .ack               (ack),
    .parallelPort_dout (dout),
    .strobe            (strobe),
    .busy              (busy),
    .owner             (owner),
    .timeout_err       (timeout_err)
  );

  // Printer model: ack = strobe delayed two clocks, or held low.
  logic ack_d1 = 1'b0;
  logic ack_tie0 = 1'b0;
  always @(posedge clk) begin
    ack_d1 <= strobe;
    ack    <= ack_tie0 ? 1'b0 : ack_d1;
  end

  // ---------------- scoreboard state ----------------
  logic [8:0]       exp_q[$];
  logic [N_REQ-1:0] exp_g_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int gnt_cnt  = 0;
  int stb_cnt  = 0;
  int last_rise = 0;
  bit has_prev  = 1'b0;
  bit chk_period = 1'b0;
  bit consume   = 1'b1;
  logic strobe_q = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  // ---------------- driver / monitor ----------------
  // Advance one clock and sample on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (grant != '0) begin
      gnt_cnt++;
      if (exp_g_q.size() == 0) check_eq("unexpected_grant", 32'(grant), 32'd0);
      else check_eq("grant", 32'(grant), 32'(exp_g_q.pop_front()));
      if (consume) req = req & ~grant;
    end
    if (strobe && !strobe_q) begin
      stb_cnt++;
      check_eq("parity", 32'(^dout), 32'd1);
      if (exp_q.size() == 0) check_eq("unexpected_strobe", 32'(exp_q.size()), 32'd1);
      else check_eq("strobe_dout", 32'(dout), 32'(exp_q.pop_front()));
      if (chk_period && has_prev) check_eq("byte_period", 32'(cyc - last_rise), 32'(PERIOD));
      last_rise = cyc;
      has_prev  = 1'b1;
    end
    strobe_q = strobe;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int bound);
    int g0 = gnt_cnt;
    for (int n = 0; n < bound; n++) begin
      step();
      if (gnt_cnt != g0) break;
    end
    check_eq("grant_wait", 32'(gnt_cnt), 32'(g0 + 1));
  endtask

  task automatic run_until_idle(input int bound);
    for (int n = 0; n < bound; n++) begin
      if (!busy) break;
      step();
    end
    check_eq("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic post(input int idx, input logic [7:0] b, input logic [8:0] exp_dout);
    exp_g_q.push_back(N_REQ'(1) << idx);
    exp_q.push_back(exp_dout);
    req_data[8*idx +: 8] = b;
    req[idx] = 1'b1;
  endtask

  // One complete byte from requester idx.
  task automatic send_one(input int idx, input logic [7:0] b, input logic [8:0] exp_dout);
    post(idx, b, exp_dout);
    wait_grant(20);
    check_eq("dout_at_grant", 32'(dout), 32'(exp_dout));
    check_eq("owner", 32'(owner), 32'(idx));
    check_eq("strobe_before_setup", 32'(strobe), 32'd0);
    step();
    check_eq("grant_pulse_width", 32'(grant), 32'd0);
    run_until_idle(40);
    check_eq("ack_low_at_idle", 32'(ack), 32'd0);
  endtask

  // ---------------- tests ----------------
  initial begin
    int hi;
    int g_before;

    // Reset values
    do_reset();
    check_eq("rst_grant",  32'(grant),       32'd0);
    check_eq("rst_strobe", 32'(strobe),      32'd0);
    check_eq("rst_busy",   32'(busy),        32'd0);
    check_eq("rst_owner",  32'(owner),       32'd0);
    check_eq("rst_tout",   32'(timeout_err), 32'd0);
    check_eq("rst_dout",   32'(dout),        32'h100);

    // 1: single request from requester 2, byte 0x41 (two ones -> parity 1)
    send_one(2, 8'h41, 9'h141);
    check_eq("t1_strobes", 32'(stb_cnt), 32'd1);
    check_eq("t1_grants",  32'(gnt_cnt), 32'd1);

    // 2: round robin with all requesters held high
    do_reset();
    consume = 1'b0;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    foreach (exp_g_q[i]) exp_g_q.delete(i);
    exp_g_q.push_back(4'b0001); exp_q.push_back(9'h010);
    exp_g_q.push_back(4'b0010); exp_q.push_back(9'h111);
    exp_g_q.push_back(4'b0100); exp_q.push_back(9'h112);
    exp_g_q.push_back(4'b1000); exp_q.push_back(9'h013);
    exp_g_q.push_back(4'b0001); exp_q.push_back(9'h010);
    g_before = gnt_cnt;
    hi = stb_cnt;
    req = 4'b1111;
    chk_period = 1'b1;
    has_prev   = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (stb_cnt == hi + 5) break;
      step();
    end
    req = '0;
    chk_period = 1'b0;
    check_eq("t2_strobes", 32'(stb_cnt - hi), 32'd5);
    run_until_idle(40);
    check_eq("t2_grants", 32'(gnt_cnt - g_before), 32'd5);
    check_eq("t2_owner",  32'(owner), 32'd0);
    consume = 1'b1;

    // 3: parity corner bytes
    do_reset();
    send_one(1, 8'h00, 9'h100);
    send_one(3, 8'h7F, 9'h07F);
    send_one(0, 8'hFF, 9'h1FF);

    // 4: reset while strobe is high
    do_reset();
    post(0, 8'h55, 9'h155);
    for (int n = 0; n < 20; n++) begin
      if (strobe) break;
      step();
    end
    check_eq("t4_strobe_seen", 32'(strobe), 32'd1);
    g_before = gnt_cnt;
    reset = 1'b1;
    step();
    check_eq("t4_strobe", 32'(strobe), 32'd0);
    check_eq("t4_busy",   32'(busy),   32'd0);
    check_eq("t4_dout",   32'(dout),   32'h100);
    reset = 1'b0;
    for (int n = 0; n < 12; n++) step();
    check_eq("t4_no_regrant", 32'(gnt_cnt), 32'(g_before));
    check_eq("t4_still_idle", 32'(busy),    32'd0);

    // 5: ack never arrives
    do_reset();
    ack_tie0 = 1'b1;
    post(3, 8'h5A, 9'h15A);
    wait_grant(20);
    for (int n = 0; n < 20; n++) begin
      if (strobe) break;
      step();
    end
    hi = 0;
    while (strobe && hi < 30) begin
      hi++;
      step();
    end
`ifdef PARPORT_ACK_TIMEOUT_EN
    check_eq("t5_strobe_len", 32'(hi),          32'(TIMEOUT_CYC));
    check_eq("t5_strobe_low", 32'(strobe),      32'd0);
    check_eq("t5_busy",       32'(busy),        32'd0);
    check_eq("t5_tout_set",   32'(timeout_err), 32'd1);
    ack_tie0 = 1'b0;
    for (int n = 0; n < 5; n++) step();
    check_eq("t5_tout_sticky", 32'(timeout_err), 32'd1);
    send_one(0, 8'h22, 9'h122);
    check_eq("t5_tout_after", 32'(timeout_err), 32'd1);
`else
    check_eq("t5_strobe_held", 32'(hi),          32'd30);
    check_eq("t5_strobe_high", 32'(strobe),      32'd1);
    check_eq("t5_tout_zero",   32'(timeout_err), 32'd0);
    ack_tie0 = 1'b0;
    run_until_idle(40);
    send_one(0, 8'h22, 9'h122);
    check_eq("t5_tout_after", 32'(timeout_err), 32'd0);
`endif

    // 6: late requester waits across a busy byte
    do_reset();
    post(1, 8'hA1, 9'h0A1);
    wait_grant(20);
    post(0, 8'hB0, 9'h0B0);
    run_until_idle(40);
    check_eq("t6_idle_no_grant", 32'(grant), 32'd0);
    step();
    check_eq("t6_late_grant", 32'(grant), 32'b0001);
    check_eq("t6_late_busy",  32'(busy),  32'd1);
    run_until_idle(40);

    check_eq("exp_q_drained",   32'(exp_q.size()),   32'd0);
    check_eq("exp_g_q_drained", 32'(exp_g_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a loop above misbehaves.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
